key_debouncer: RTL
==================

// Module: key_debouncer
// PURPOSE
//   Input-side conditioner for board push-buttons. Synchronises N raw key pins to
//   clk50_i, debounces each one independently, and produces clean levels plus
//   one-cycle press/release strobes. Sits between the board keys and the
//   enable/step inputs of counters and registers.
// PARAMETERS
//   N_KEYS          2          number of independent key channels
//   DEBOUNCE_CYCLES 1_000_000  cycles a new level must hold before acceptance (20 ms @ 50 MHz); >=2
//   LONG_CYCLES     50_000_000 press duration for the long-press strobe (1 s); > DEBOUNCE_CYCLES
//   KEY_ACTIVE_LOW  1          1: pin=0 means pressed; 0: pin=1 means pressed
// PORTS
//   clk50_i    in   1       system clock, 50 MHz
//   arst_i     in   1       asynchronous reset, active-low
//   key_i      in   N_KEYS  raw asynchronous key pins
//   key_o      out  N_KEYS  debounced level, 1 = pressed
//   press_o    out  N_KEYS  1-cycle strobe on accepted press
//   release_o  out  N_KEYS  1-cycle strobe on accepted release
//   long_o     out  N_KEYS  1-cycle strobe when a press has lasted LONG_CYCLES
// BEHAVIOUR
//   - Clock clk50_i; reset asynchronous, active-low on arst_i. All state is per key.
//   - Sync: 2-FF synchroniser per key, reset to the released pin level (1 if
//     KEY_ACTIVE_LOW), so reset never produces a press. Output polarity normalised: 1 = pressed.
//   - Per-key FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND; reset -> RELEASED.
//     RELEASED: sync=pressed -> PRESS_PEND, cnt<=0.
//     PRESS_PEND: sync=released -> RELEASED (glitch rejected); else cnt++;
//       cnt==DEBOUNCE_CYCLES-1 -> PRESSED, press_o=1 next cycle, hold counter cleared.
//     PRESSED: sync=released -> RELEASE_PEND, cnt<=0.
//     RELEASE_PEND: sync=pressed -> PRESSED (glitch rejected, hold counter kept);
//       cnt==DEBOUNCE_CYCLES-1 -> RELEASED, release_o=1 next cycle.
//   - key_o=1 in PRESSED and RELEASE_PEND, else 0; registered.
//   - Latency: pin edge -> key_o/strobe = 2 sync + DEBOUNCE_CYCLES cycles, fixed.
//   - Debounce counter width $clog2(DEBOUNCE_CYCLES); saturates, never wraps.
//   - press_o/release_o never assert together for one key; exactly one press per
//     release; strobes are exactly 1 cycle wide.
//   - Reset outputs: key_o=0, press_o=0, release_o=0, long_o=0; counters 0.
//   - Reset mid-press: channel returns to RELEASED; a still-held key is re-accepted
//     only after a full debounce after reset release (press_o fires once).
//   - Channels fully independent; simultaneous events on several keys all reported
//     in the same cycle.
// CONFIGURATION
//   LONG_PRESS_EN defined: per-key hold counter ($clog2(LONG_CYCLES) bits) runs in
//     PRESSED/RELEASE_PEND, counting from press_o; long_o pulses once when it reaches
//     LONG_CYCLES-1, then saturates (no repeat) until release. Counter cleared on release.
//   LONG_PRESS_EN undefined: no hold counter synthesised; long_o tied to 0.
// TESTING (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, N_KEYS=2, KEY_ACTIVE_LOW=1)
//   1 Reset with key_i=2'b11 held, release arst_i -> all outputs 0 for 20 cycles.
//   2 key_i[0] 1->0 held -> press_o[0] single pulse and key_o[0]=1 exactly 6 cycles
//     after edge; key_i[0] 0->1 -> release_o[0] pulse 6 cycles later, key_o[0]=0.
//   3 key_i[0] low for 3 cycles then high -> no press_o, key_o stays 0; same for a
//     3-cycle high glitch while pressed -> no release_o, key_o stays 1.
//   4 Both keys pressed on same cycle -> press_o=2'b11 in one cycle, one pulse each.
//   5 LONG_PRESS_EN: hold key_i[1] low 30 cycles -> long_o[1] one pulse 9 cycles after
//     press_o[1], no second pulse; without macro long_o stays 0.
//   6 Assert arst_i while key_o[0]=1, keep key low, deassert -> outputs 0 during
//     reset, then press_o[0] fires once 6 cycles after deassertion.

Source files
------------

// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, per-key debounce FSM, press/release strobes.
// Define LONG_PRESS_EN to build the per-key hold counter and long_o strobe; otherwise long_o is 0.
module key_debouncer #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk50_i,
  input  logic              arst_i,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] long_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] PIN_IDLE = {N_KEYS{KEY_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } key_state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("key_debouncer: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] pressed;

  // Synchroniser resets to the idle pin level so leaving reset never looks like a press
  always_ff @(posedge clk50_i or negedge arst_i) begin
    if (!arst_i) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_d;
    logic             release_d;
    logic             key_q;
    logic             press_q;
    logic             release_q;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // The entry cycle into a pending state counts as the first debounce cycle
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        RELEASED: begin
          if (pressed[k]) begin
            state_d = PRESS_PEND;
            cnt_d   = '0;
          end
        end
        PRESS_PEND: begin
          if (!pressed[k]) begin
            state_d = RELEASED;
          end else if (cnt_inc == CNT_MAX) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          if (!pressed[k]) begin
            state_d = RELEASE_PEND;
            cnt_d   = '0;
          end
        end
        RELEASE_PEND: begin
          if (pressed[k]) begin
            state_d = PRESSED;
          end else if (cnt_inc == CNT_MAX) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk50_i or negedge arst_i) begin
      if (!arst_i) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        key_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        key_q     <= (state_d == PRESSED) || (state_d == RELEASE_PEND);
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_o[k]     = key_q;
    assign press_o[k]   = press_q;
    assign release_o[k] = release_q;

`ifdef LONG_PRESS_EN
    localparam int               HOLD_W   = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 2);

    logic [HOLD_W-1:0] hold_q;
    logic              long_q;

    // Hold time restarts at the press strobe and survives rejected release glitches
    always_ff @(posedge clk50_i or negedge arst_i) begin
      if (!arst_i) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else if (press_d || (state_d == RELEASED)) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else if (((state_q == PRESSED) || (state_q == RELEASE_PEND)) && (hold_q != HOLD_MAX)) begin
        hold_q <= hold_q + 1'b1;
        long_q <= (hold_q == HOLD_PRE);
      end else begin
        long_q <= 1'b0;
      end
    end

    assign long_o[k] = long_q;
`else
    assign long_o[k] = 1'b0;
`endif
  end

endmodule
